// File: rtl/reduce_pkg.sv
// Shared definitions for the run-length job scheduler: state encodings,
// parameter defaults and the hit-counter width helper.
// Latency: n/a (package). Backpressure: n/a (package).
package reduce_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Run detector states: how many consecutive ones have been seen (saturating at two).
  typedef enum logic [1:0] {
    DET_ZERO = 2'd0,
    DET_ONE  = 2'd1,
    DET_TWO  = 2'd2
  } det_e;

  // A W-bit word holds at most W-1 overlapping "11" pairs, so log2(W)+1 bits suffice.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/reduce_sched_run_detect.sv
// Moore detector for two consecutive ones in a serial bit stream.
// Latency: out reflects bits fed up to the previous clock edge. Backpressure: none, one bit per cycle.
// Ports: clk, reset (async active-low), clr (sync return to zero-ones state), in (serial bit), out (last two bits were 1).
module run_detect
  import reduce_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic in,
  output logic out
);

  det_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_ZERO;
    end else if (!in) begin
      state_d = DET_ZERO;
    end else begin
      case (state_q)
        DET_ZERO: state_d = DET_ONE;
        DET_ONE:  state_d = DET_TWO;
        DET_TWO:  state_d = DET_TWO;
        default:  state_d = DET_ZERO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DET_ZERO;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = (state_q == DET_TWO);

endmodule

// File: rtl/reduce_sched.sv
// Round-robin job scheduler: grants one requester, serially counts overlapping "11" pairs in its word.
// Latency: done pulses W+2 cycles after the gnt cycle; next grant no sooner than W+3 cycles after gnt.
// Backpressure: requesters hold req level until granted; arbitration only while idle, req ignored otherwise.
// Ports: req/din (per-requester request + packed W-bit words), gnt (one-hot capture pulse),
//        busy (job in flight), done (result pulse), done_id/hit_count (held result).
module reduce_sched
  import reduce_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       din,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [cnt_width(W)-1:0]  hit_count
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = cnt_width(W);
  localparam int unsigned BW  = $clog2(W);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   job_id_q;
  logic [IDW-1:0]   done_id_q;
  logic [W-1:0]     shreg_q;
  logic [BW-1:0]    bcnt_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    hit_q;

  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic [N_REQ-1:0] win_oh;
  logic             det_out;
  logic             det_clr;
  logic             det_in;

  // Round-robin search starting at the priority pointer.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);
  end

  // Grant is qualified by reset so it reads zero while reset is held, even with req high.
  always_comb begin
    win_oh = '0;
    if (state_q == ST_IDLE && win_vld && reset) begin
      win_oh[win_id] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_vld) state_d = ST_SHIFT;
      ST_SHIFT: if (bcnt_q == BW'(W - 1)) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      job_id_q  <= '0;
      done_id_q <= '0;
      shreg_q   <= '0;
      bcnt_q    <= '0;
      cnt_q     <= '0;
      hit_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            shreg_q  <= din[int'(win_id)*W +: W];
            job_id_q <= win_id;
            ptr_q    <= ptr_d;
            bcnt_q   <= '0;
            cnt_q    <= '0;
          end
        end
        ST_SHIFT: begin
          shreg_q <= shreg_q << 1;
          bcnt_q  <= bcnt_q + BW'(1);
          if (det_out) cnt_q <= cnt_q + CW'(1);
        end
        ST_FLUSH: begin
          // Final count includes the detector state after the last bit; publish it for DONE.
          cnt_q     <= cnt_q + CW'(det_out);
          hit_q     <= cnt_q + CW'(det_out);
          done_id_q <= job_id_q;
        end
        default: ;
      endcase
    end
  end

  // Detector is held clear while idle, so the first SHIFT cycle always sees the zero-ones state.
  assign det_clr = (state_q == ST_IDLE);
  assign det_in  = shreg_q[W-1];

  run_detect u_run_detect (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .in    (det_in),
    .out   (det_out)
  );

  assign gnt       = win_oh;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign done_id   = done_id_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_reduce_sched.sv
module tb_reduce_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [DW-1:0] din;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          done;
  logic [1:0]    done_id;
  logic [3:0]    hit_count;

  always #5 clk = ~clk;

  reduce_sched #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: cycles elapsed since the last grant (-1 when idle), pointer, job and held results.
  int m_since     = -1;
  int m_ptr       = 0;
  int m_job_id    = 0;
  int m_job_hits  = 0;
  int m_last_id   = 0;
  int m_last_hits = 0;

  typedef struct {
    logic [N-1:0] r;
    int           lane;
    logic [W-1:0] word;
    logic [N-1:0] gnt;
    int           id;
    int           hits;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pairs(input logic [W-1:0] w);
    int c;
    c = 0;
    for (int j = 0; j < W - 1; j++) if (w[j] && w[j+1]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] mkdin(input int lane, input logic [W-1:0] word);
    logic [DW-1:0] d;
    d = DW'($urandom);
    d[lane*W +: W] = word;
    return d;
  endfunction

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic tick(input logic [N-1:0] r, input logic [DW-1:0] d);
    logic [N-1:0] eg;
    int win;
    @(posedge clk);
    #1;
    req = r;
    din = d;
    #3;
    if (m_since >= 0) m_since++;
    if (m_since > W + 2) m_since = -1;
    eg  = '0;
    win = -1;
    if (m_since < 0) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    if (m_since == W + 2) begin
      m_last_id   = m_job_id;
      m_last_hits = m_job_hits;
    end
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(m_since >= 1));
    check("done", 32'(done), 32'(m_since == W + 2));
    check("done_id", 32'(done_id), m_last_id);
    check("hit_count", 32'(hit_count), m_last_hits);
    if (win >= 0) begin
      m_job_id   = win;
      m_job_hits = pairs(d[win*W +: W]);
      m_ptr      = (win + 1) % N;
      m_since    = 0;
    end
  endtask

  // Assert reset away from the clock edge, confirm outputs clear at once, then release.
  task automatic apply_reset(input logic [N-1:0] r);
    @(posedge clk);
    #1;
    req   = r;
    reset = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_hit_count", 32'(hit_count), 0);
    @(posedge clk);
    #2;
    check("rst_hold_done", 32'(done), 0);
    @(posedge clk);
    #1;
    req         = '0;
    reset       = 1'b1;
    m_since     = -1;
    m_ptr       = 0;
    m_last_id   = 0;
    m_last_hits = 0;
  endtask

  initial begin
    int gt[$];
    logic [N-1:0] gv[$];
    int nfound;

    reset = 1'b0;
    req   = '0;
    din   = '0;

    tbl[0] = '{4'b0001, 0, 8'hFF, 4'b0001, 0, 7};
    tbl[1] = '{4'b0100, 2, 8'h00, 4'b0100, 2, 0};
    tbl[2] = '{4'b0100, 2, 8'hAA, 4'b0100, 2, 0};
    tbl[3] = '{4'b0100, 2, 8'hCC, 4'b0100, 2, 2};
    tbl[4] = '{4'b0100, 2, 8'hF0, 4'b0100, 2, 3};
    tbl[5] = '{4'b0100, 2, 8'h0F, 4'b0100, 2, 3};
    tbl[6] = '{4'b1000, 3, 8'h7F, 4'b1000, 3, 6};

    apply_reset('0);
    repeat (2) tick('0, '0);

    // Table-driven single jobs; din is zeroed right after the grant cycle.
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].r, mkdin(tbl[i].lane, tbl[i].word));
      check("tbl_gnt", 32'(gnt), 32'(tbl[i].gnt));
      repeat (W + 1) tick('0, '0);
      tick('0, '0);
      check("tbl_done", 32'(done), 1);
      check("tbl_done_id", 32'(done_id), tbl[i].id);
      check("tbl_hits", 32'(hit_count), tbl[i].hits);
    end

    // Din and req change after grant must not affect the running job.
    tick(4'b0001, mkdin(0, 8'hFF));
    check("chg_gnt", 32'(gnt), 32'b0001);
    repeat (W + 1) tick(4'b0100, '0);
    tick(4'b0100, '0);
    check("chg_done", 32'(done), 1);
    check("chg_hits", 32'(hit_count), 7);
    check("chg_id", 32'(done_id), 0);
    tick(4'b0100, '0);
    check("chg_next_gnt", 32'(gnt), 32'b0100);
    repeat (W + 2) tick('0, '0);

    // Fairness with all requesters held high.
    apply_reset('0);
    for (int c = 0; c < 46; c++) begin
      tick(4'b1111, DW'($urandom));
      if (gnt != '0) begin
        gt.push_back(c);
        gv.push_back(gnt);
      end
    end
    check("fair_count", gt.size(), 5);
    nfound = (gt.size() < 5) ? gt.size() : 5;
    for (int i = 0; i < nfound; i++) begin
      check("fair_gnt", 32'(gv[i]), 32'(1 << (i % N)));
      if (i > 0) check("fair_space", gt[i] - gt[i-1], W + 3);
    end
    repeat (W + 2) tick('0, '0);

    // Pointer wrap: after granting 1, pointer is 2; req 0011 wraps to requester 0.
    apply_reset('0);
    tick(4'b0010, DW'($urandom));
    check("ptr_first", 32'(gnt), 32'b0010);
    repeat (W + 2) tick('0, '0);
    tick(4'b0011, DW'($urandom));
    check("ptr_wrap", 32'(gnt), 32'b0001);
    repeat (W + 2) tick('0, '0);

    // Reset mid-job: leave a nonzero result held first, then abort in the 5th SHIFT cycle.
    apply_reset('0);
    tick(4'b1000, mkdin(3, 8'hFF));
    repeat (W + 2) tick('0, '0);
    check("pre_rst_hits", 32'(hit_count), 7);
    tick(4'b0001, mkdin(0, 8'hFF));
    repeat (4) tick('0, '0);
    apply_reset(4'b1111);
    tick(4'b1010, DW'($urandom));
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    repeat (W + 3) tick('0, '0);

    // Randomized traffic against the model.
    apply_reset('0);
    for (int c = 0; c < 500; c++) begin
      tick(N'($urandom) & N'($urandom), DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
